// File: rtl/zero_search_pkg.sv
// Shared types and constants for the first-zero search scheduler.
package zero_search_pkg;
    localparam int WORD_W  = 8;
    localparam int POS_W   = 3;
    localparam int ID_MAXW = 3;

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DONE, RESP} state_e;

    typedef struct packed {
        logic [ID_MAXW-1:0] id;
        logic               found;
        logic [POS_W-1:0]   pos;
    } rsp_t;
endpackage

// File: rtl/zero_search_sched_finder.sv
// Serial first-zero finder: watches one bit per enabled cycle and latches the
// index of the first 0 seen since the last clear.
module first_zero_finder
    import zero_search_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic             o_found,
    output logic [POS_W-1:0] o_pos
);
    logic [POS_W-1:0] r_k;
    logic             r_found;
    logic [POS_W-1:0] r_pos;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k     <= '0;
            r_found <= 1'b0;
            r_pos   <= '0;
        end else if (i_clr) begin
            r_k     <= '0;
            r_found <= 1'b0;
            r_pos   <= '0;
        end else if (i_en) begin
            r_k <= r_k + 1'b1;
            if (!r_found && !i_bit) begin
                r_found <= 1'b1;
                r_pos   <= r_k;
            end
        end
    end

    assign o_found = r_found;
    assign o_pos   = r_pos;
endmodule

// File: rtl/zero_search_sched.sv
// Round-robin arbiter sharing one serial first-zero finder between NREQ
// requesters; results return over a valid/ready channel.
module zero_search_sched
    import zero_search_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req,
    input  logic [WORD_W*NREQ-1:0]   i_req_data,
    output logic [NREQ-1:0]          o_ack,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [IDW-1:0]           o_rsp_id,
    output logic                     o_rsp_found,
    output logic [POS_W-1:0]         o_rsp_pos,
    output logic                     o_busy,
    output logic [CNTW-1:0]          o_ones_cnt
);
    state_e              r_state, w_next;
    logic [NREQ-1:0]     r_ack, w_gnt_oh;
    logic                w_gnt_vld;
    logic [IDW-1:0]      w_gnt_id, r_last, r_cur_id;
    logic [WORD_W-1:0]   w_gnt_word, r_word;
    logic [POS_W-1:0]    r_bitcnt;
    logic [CNTW-1:0]     r_ones_cnt;
    rsp_t                r_rsp;
    logic                w_fz_found;
    logic [POS_W-1:0]    w_fz_pos;
    int                  w_best;

    // Rank each requester by its distance past the last grant; nearest wins.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_id   = '0;
        w_gnt_oh   = '0;
        w_gnt_word = '0;
        w_best     = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            if (i_req[j] && ((j + NREQ - 1 - int'(r_last)) % NREQ) < w_best) begin
                w_best     = (j + NREQ - 1 - int'(r_last)) % NREQ;
                w_gnt_vld  = 1'b1;
                w_gnt_id   = IDW'(j);
                w_gnt_oh   = '0;
                w_gnt_oh[j] = 1'b1;
                w_gnt_word = i_req_data[WORD_W*j +: WORD_W];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_gnt_vld) w_next = CLEAR;
            CLEAR:   w_next = SHIFT;
            SHIFT:   if (r_bitcnt == POS_W'(WORD_W-1)) w_next = DONE;
            DONE:    w_next = RESP;
            RESP:    if (i_rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack      <= '0;
            r_last     <= IDW'(NREQ-1);
            r_cur_id   <= '0;
            r_word     <= '0;
            r_bitcnt   <= '0;
            r_rsp      <= '0;
            r_ones_cnt <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: if (w_gnt_vld) begin
                    r_ack    <= w_gnt_oh;
                    r_word   <= w_gnt_word;
                    r_cur_id <= w_gnt_id;
                    r_last   <= w_gnt_id;
                end
                CLEAR: r_bitcnt <= '0;
                SHIFT: r_bitcnt <= r_bitcnt + 1'b1;
                DONE: begin
                    r_rsp <= '{id: ID_MAXW'(r_cur_id), found: w_fz_found, pos: w_fz_pos};
                    if (!w_fz_found && r_ones_cnt != '1) r_ones_cnt <= r_ones_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    first_zero_finder u_finder (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (r_state == CLEAR),
        .i_en    (r_state == SHIFT),
        .i_bit   (r_word[r_bitcnt]),
        .o_found (w_fz_found),
        .o_pos   (w_fz_pos)
    );

    assign o_ack       = r_ack;
    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_id    = IDW'(r_rsp.id);
    assign o_rsp_found = r_rsp.found;
    assign o_rsp_pos   = r_rsp.pos;
    assign o_busy      = (r_state != IDLE);
    assign o_ones_cnt  = r_ones_cnt;
endmodule

// File: tb/tb_zero_search_sched.sv
// Bench for zero_search_sched: cycle-level reference model plus directed jobs.
module tb_zero_search_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [8*NREQ-1:0]    req_data = '0;
    logic                 rsp_ready = 1'b1;
    logic [NREQ-1:0]      ack, ack2;
    logic                 valid, valid2, found, found2, busy, busy2;
    logic [IDW-1:0]       rid, rid2;
    logic [2:0]           pos, pos2;
    logic [15:0]          cnt;
    logic [1:0]           cnt2;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    zero_search_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_data(req_data),
        .o_ack(ack), .o_rsp_valid(valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rid), .o_rsp_found(found), .o_rsp_pos(pos),
        .o_busy(busy), .o_ones_cnt(cnt));

    zero_search_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_data(req_data),
        .o_ack(ack2), .o_rsp_valid(valid2), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rid2), .o_rsp_found(found2), .o_rsp_pos(pos2),
        .o_busy(busy2), .o_ones_cnt(cnt2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // {found, pos} of the lowest 0 bit
    function automatic logic [3:0] ffz(input logic [7:0] w);
        for (int i = 0; i < 8; i++) if (!w[i]) return {1'b1, 3'(i)};
        return 4'b0;
    endfunction

    function automatic int rr(input logic [NREQ-1:0] r, input int last);
        logic [NREQ-1:0] rv;
        for (int o = 1; o <= NREQ; o++) begin
            rv = r >> ((last + o) % NREQ);
            if (rv[0]) return (last + o) % NREQ;
        end
        return 0;
    endfunction

    // Reference model: a job granted while idle acks next cycle (t), its
    // result is loaded at t+9 and presented from t+10 until accepted.
    bit              m_busy;
    int              m_t, m_last, m_id, m_rid, m_cnt, m_cnt2, g;
    logic [7:0]      m_word;
    logic [NREQ-1:0] m_ack;
    logic [3:0]      m_res;
    logic [31:0]     tmp;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_last = NREQ - 1; m_ack = '0; m_res = '0;
            m_rid = 0; m_cnt = 0; m_cnt2 = 0;
        end
        chk("ack",    32'(ack),    32'(m_ack));
        chk("ack2",   32'(ack2),   32'(m_ack));
        chk("busy",   32'(busy),   32'(m_busy));
        chk("busy2",  32'(busy2),  32'(m_busy));
        chk("valid",  32'(valid),  32'(m_busy && cyc >= m_t + 10));
        chk("valid2", 32'(valid2), 32'(m_busy && cyc >= m_t + 10));
        chk("rsp_id", 32'(rid),    m_rid);
        chk("rsp_id2",32'(rid2),   m_rid);
        chk("found",  32'(found),  32'(m_res[3]));
        chk("found2", 32'(found2), 32'(m_res[3]));
        chk("pos",    32'(pos),    32'(m_res[2:0]));
        chk("pos2",   32'(pos2),   32'(m_res[2:0]));
        chk("cnt",    32'(cnt),    m_cnt);
        chk("cnt2",   32'(cnt2),   m_cnt2);
        if (rst_n) begin
            m_ack = '0;
            if (m_busy) begin
                if (cyc == m_t + 9) begin
                    m_res = ffz(m_word);
                    m_rid = m_id;
                    if (m_word == 8'hFF) begin
                        if (m_cnt < 65535) m_cnt++;
                        if (m_cnt2 < 3) m_cnt2++;
                    end
                end
                if (cyc >= m_t + 10 && rsp_ready) m_busy = 0;
            end else if (req != '0) begin
                g = rr(req, m_last);
                m_ack = '0;
                m_ack[g] = 1'b1;
                m_busy = 1; m_t = cyc + 1; m_id = g; m_last = g;
                tmp = req_data >> (8 * g);
                m_word = tmp[7:0];
            end
        end
    end

    task automatic set_word(input int r, input logic [7:0] w);
        req_data = (req_data & ~(32'hFF << (8 * r))) | (32'(w) << (8 * r));
    endtask

    task automatic wait_ack(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack != '0) begin t = cyc; break; end
        end
        if (t < 0) chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) begin t = cyc; break; end
        end
        if (t < 0) chk("valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (ok == 0) chk("idle_timeout", 0, 1);
    endtask

    // One single-requester job with ready held high; req drops after ACK.
    task automatic job(input int r, input logic [7:0] w, output int ta, output int tv);
        @(posedge clk); #1;
        set_word(r, w);
        req = NREQ'(1) << r;
        wait_ack(ta);
        @(posedge clk); #1;
        req = '0;
        wait_valid(tv);
    endtask

    initial begin
        int ta, tv, prev, id, hs;
        int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int sat[5]   = '{1, 2, 3, 3, 3};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_cnt", 32'(cnt), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // basic job: 1111_0111 -> zero at bit 3
        @(posedge clk); #1;
        set_word(0, 8'b1111_0111);
        req = 4'b0001;
        wait_ack(ta);
        chk("t1_ack", 32'(ack), 32'h1);
        @(posedge clk); #1 req = '0;
        wait_valid(tv);
        chk("t1_lat", tv - ta, 10);
        chk("t1_id", 32'(rid), 0);
        chk("t1_found", 32'(found), 1);
        chk("t1_pos", 32'(pos), 3);
        @(negedge clk);
        chk("t1_idle", 32'(busy), 0);

        job(0, 8'hFF, ta, tv);
        chk("ff_found", 32'(found), 0);
        chk("ff_pos", 32'(pos), 0);
        chk("ff_cnt", 32'(cnt), 1);
        job(0, 8'h7F, ta, tv);
        chk("7f_found", 32'(found), 1);
        chk("7f_pos", 32'(pos), 7);
        job(0, 8'h00, ta, tv);
        chk("00_pos", 32'(pos), 0);
        chk("00_cnt", 32'(cnt), 1);

        // leave last=3 so the all-request sweep starts at 0
        job(3, 8'hEF, ta, tv);
        chk("ef_pos", 32'(pos), 4);
        chk("ef_id", 32'(rid), 3);

        @(posedge clk); #1;
        set_word(0, 8'hFE); set_word(1, 8'hFD); set_word(2, 8'hDF); set_word(3, 8'h7F);
        req = 4'b1111;
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            wait_ack(ta);
            id = -1;
            for (int j = 0; j < NREQ; j++) if (ack[j]) id = j;
            chk("rr_order", id, order[k]);
            if (prev >= 0) chk("rr_spacing", ta - prev, 12);
            prev = ta;
        end
        @(posedge clk); #1 req = '0;
        wait_idle();

        // back-pressure with a re-request pending on requester 1
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_word(1, 8'hFB);
        req = 4'b0010;
        wait_ack(ta);
        wait_valid(tv);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_valid", 32'(valid), 1);
            chk("bp_id", 32'(rid), 1);
            chk("bp_pos", 32'(pos), 2);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        hs = tv + 5;
        wait_ack(ta);
        chk("bp_reack", 32'(ack), 32'h2);
        chk("bp_gap", ta - hs, 2);
        @(posedge clk); #1 req = '0;
        wait_valid(tv);

        // reset while the finder is at bit 4
        @(posedge clk); #1;
        set_word(2, 8'hBF);
        req = 4'b0100;
        wait_ack(ta);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        set_word(0, 8'hF0);
        req = 4'b0101;
        @(negedge clk);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_valid", 32'(valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ack(ta);
        chk("mr_prio", 32'(ack), 32'h1);
        @(posedge clk); #1 req = 4'b0100;
        wait_valid(tv);
        wait_ack(ta);
        chk("mr_second", 32'(ack), 32'h4);
        @(posedge clk); #1 req = '0;
        wait_valid(tv);
        chk("mr_pos", 32'(pos), 6);

        // saturation of the narrow counter
        for (int k = 0; k < 5; k++) begin
            job(0, 8'hFF, ta, tv);
            chk("sat_cnt2", 32'(cnt2), sat[k]);
            chk("sat_cnt", 32'(cnt), k + 1);
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule

// File: doc/zero_search_sched.md
Name: zero_search_sched

Overview:
- Round-robin scheduler that shares one serial first-zero finder between NREQ requesters.
- Each requester offers an 8-bit word. The scheduler grants one requester and clears the finder.
- It then streams the word LSB-first into the finder, one bit per cycle, and returns the index of the first 0 bit (or "no zero") to the granted requester over a valid/ready response channel.
- It sits between the requesting datapath blocks and the finder, and owns all finder sequencing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ.
- CNTW, 16, width of the saturating all-ones statistics counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  NREQ  request per requester; level, held until ACK.
- REQ_DATA  in  8*NREQ  word for requester i is REQ_DATA[8*i+7:8*i]; stable while REQ[i]=1.
- ACK  out  NREQ  one-cycle pulse on the granted bit in the cycle its word is captured.
- RSP_VALID  out  1  result available; held until accepted.
- RSP_READY  in  1  result consumer ready.
- RSP_ID  out  IDW  ID of the requester the result belongs to.
- RSP_FOUND  out  1  1 if the word contained at least one 0.
- RSP_POS  out  3  index of lowest 0 bit; 0 when RSP_FOUND=0.
- BUSY  out  1  high in every state except IDLE.
- ONES_CNT  out  CNTW  count of completed words equal to 8'hFF; saturates at all-ones.

Behaviour:
- Reset (RST_N=0, immediate):
  - state=IDLE; ACK=0, RSP_VALID=0, RSP_ID=0, RSP_FOUND=0, RSP_POS=0, BUSY=0, ONES_CNT=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Finder cleared.
- FSM states: IDLE, CLEAR, SHIFT, DONE, RESP.
- IDLE:
  - If any REQ bit is set, grant the first set bit searching from (last+1) mod NREQ upward, with wrap.
  - In that same cycle: ACK[g]=1, capture REQ_DATA word g and ID g, set last=g, go to CLEAR.
  - If no REQ bit is set, stay in IDLE.
- CLEAR (1 cycle): assert finder clear; bit counter=0.
- SHIFT (8 cycles): present captured bit[k] to finder on cycle k, k=0..7. After k=7, go to DONE. No early termination; latency is fixed.
- DONE (1 cycle):
  - Load RSP_FOUND, RSP_POS and RSP_ID from the finder result.
  - If RSP_FOUND=0, increment ONES_CNT unless it is saturated.
  - Go to RESP.
- RESP:
  - RSP_VALID=1, with RSP_* stable.
  - On an edge where RSP_READY=1: RSP_VALID drops next cycle and state returns to IDLE.
  - Arbitration resumes in IDLE on the following cycle.
- Latency:
  - ACK in cycle t; RSP_VALID first high in cycle t+10.
  - Minimum spacing between ACKs is 12 cycles (with RSP_READY held 1).
- REQ rules:
  - REQ bits that drop before being granted are simply not granted; no error.
  - A REQ dropping after its ACK does not affect the in-flight job.
  - A requester may re-request immediately. Round-robin guarantees that every other pending requester is served before it is served again.
- Finder (sub-module) contract:
  - Clear sets found=0, pos=0.
  - Each shift cycle: if found=0 and the bit is 0, set found=1 and pos=k.
  - Later zeros are ignored.
  - A zero at k=7 is reported as found=1, pos=7.
  - 8'hFF gives found=0, pos=0.
- RSP_READY already high on entry to RESP: handshake completes that cycle; RSP_VALID is high for exactly one cycle.
- Reset mid-operation (any state): abort the job with no response and no ACK re-issue; requester must keep REQ to be re-served.
- ONES_CNT holds at 2**CNTW-1 once saturated.

Decomposition:
- Package zero_search_pkg:
  - State enum (IDLE, CLEAR, SHIFT, DONE, RESP).
  - Constant WORD_W=8 and POS_W=3.
  - Struct holding a response (id, found, pos).
- One sub-module, first_zero_finder:
  - Ports: CLK, RST_N, CLR, EN, BIT, FOUND, POS.
  - Implements the serial detection with k tracked internally.
- The scheduler contains the arbiter, FSM and counters.

Test Plan:
- Reset, then REQ=0001, word0=8'b1111_0111, RSP_READY=1 → ACK=0001 at t; RSP_VALID at t+10 with ID=0, FOUND=1, POS=3; BUSY low at t+11.
- Single requester, words 8'hFF, 8'h7F, 8'h00 in turn → (FOUND=0, POS=0, ONES_CNT 0→1), (FOUND=1, POS=7), (FOUND=1, POS=0).
- REQ=1111 held continuously, 8 jobs → grant order 0,1,2,3,0,1,2,3; ACK spacing exactly 12 cycles; each RSP_ID matches its ACK.
- RSP_READY held 0 for 5 cycles after RSP_VALID rises, REQ=0010 pending → RSP_* stable all 5 cycles; no ACK until 1 cycle after the handshake.
- RST_N pulsed low during SHIFT (k=4) → all outputs 0 immediately; no RSP_VALID; after release, requester 0 has priority over requester 2 when REQ=0101.
- CNTW=2 build, five 8'hFF words → ONES_CNT sequence 1,2,3,3,3.
